// File: rtl/ram_dp_pkg.sv
// Shared definitions for the ram_dp_sync dual-port RAM.
// Holds the read-during-write mode selectors, the clear/ready state enum and
// the even-parity helper used when RAM_DP_SYNC_PARITY_EN is defined.
package ram_dp_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest data word the parity helper accepts; callers zero-extend into it.
    localparam int PAR_MAXW = 256;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    // Even parity bit: makes the total number of ones (data + bit) even.
    function automatic logic even_parity(input logic [PAR_MAXW-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_dp_port.sv
// One access port of ram_dp_sync: request accept, out-of-range check,
// registered read data and the rvalid/oob/perr strobes.
// The parity check is only built when RAM_DP_SYNC_PARITY_EN is defined.
module ram_dp_port
    import ram_dp_pkg::*;
#(
    parameter int AW    = 11,
    parameter int DW    = 16,
    parameter int DEPTH = 2048,
    parameter int MW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ready_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [MW-1:0] rdata_i,
    output logic          wr_o,
    output logic          in_range_o,
    output logic [DW-1:0] dout_o,
    output logic          rvalid_o,
    output logic          oob_o,
    output logic          perr_o
);

    logic          accept_s;
    logic          in_range_s;
    logic          perr_d;
    logic [DW-1:0] dout_q;
    logic          rvalid_q;
    logic          oob_q;
    logic          perr_q;

    // Full-width compare so that no high address bit is silently dropped.
    assign in_range_s = ({1'b0, addr_i} < (AW+1)'(DEPTH));
    assign accept_s   = en_i & ready_i;
    assign wr_o       = accept_s & we_i & in_range_s;
    assign in_range_o = in_range_s;

    // Parity check of the word being returned; out-of-range reads never flag.
    always_comb begin
        perr_d = 1'b0;
`ifdef RAM_DP_SYNC_PARITY_EN
        if (accept_s && in_range_s) begin
            perr_d = even_parity(PAR_MAXW'(rdata_i[DW-1:0])) ^ rdata_i[DW];
        end else begin
            perr_d = 1'b0;
        end
`endif
    end

    // Output register: data updates only on accepted requests, strobes last one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
            oob_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            rvalid_q <= accept_s;
            oob_q    <= accept_s & ~in_range_s;
            perr_q   <= perr_d;
            if (accept_s) begin
                dout_q <= in_range_s ? rdata_i[DW-1:0] : '0;
            end
        end
    end

    assign dout_o   = dout_q;
    assign rvalid_o = rvalid_q;
    assign oob_o    = oob_q;
    assign perr_o   = perr_q;

endmodule

// File: rtl/ram_dp_sync.sv
// True dual-port synchronous RAM: port A for game logic, port B for the renderer.
// Holds the storage array, the power-on clear sweep and same-address collision
// handling (port A wins). Optional stored parity: define RAM_DP_SYNC_PARITY_EN.
module ram_dp_sync
    import ram_dp_pkg::*;
#(
    parameter int            AW        = 11,
    parameter int            DW        = 16,
    parameter int            DEPTH     = 2048,
    parameter int            RDW_MODE  = 0,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          init_busy,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    output logic          a_rvalid,
    output logic          a_oob,
    output logic          a_perr,
    input  logic          b_en,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic [DW-1:0] b_dout,
    output logic          b_rvalid,
    output logic          b_oob,
    output logic          b_perr,
    output logic          collision
);

`ifdef RAM_DP_SYNC_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Build the stored word (data plus parity when enabled).
    function automatic logic [MW-1:0] make_word(input logic [DW-1:0] d);
`ifdef RAM_DP_SYNC_PARITY_EN
        return {even_parity(PAR_MAXW'(d)), d};
`else
        return d;
`endif
    endfunction

    logic [MW-1:0] mem [0:DEPTH-1];

    ram_state_e    state_q;
    logic [AW-1:0] clr_ptr_q;
    logic          busy_q;
    logic          collision_q;
    logic          ready_s;
    logic          a_wr_s, b_wr_s, a_inr_s, b_inr_s, same_addr_s;
    logic [IW-1:0] a_idx_s, b_idx_s;
    logic [MW-1:0] a_word_s, b_word_s, a_rdata_s, b_rdata_s;

    assign ready_s     = (state_q == READY);
    assign same_addr_s = (a_addr == b_addr);
    assign a_idx_s     = a_addr[IW-1:0];
    assign b_idx_s     = b_addr[IW-1:0];
    assign a_word_s    = make_word(a_din);
    assign b_word_s    = make_word(b_din);

    // Clear-sweep FSM: one word per cycle from 0 to DEPTH-1, then READY until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + AW'(1);
                    end
                end
                READY: begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_ptr_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    // Storage writes: sweep during CLEAR, otherwise ports; A's data wins on a shared address.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_ptr_q[IW-1:0]] <= make_word(CLEAR_VAL);
        end else begin
            if (b_wr_s && !(a_wr_s && same_addr_s)) begin
                mem[b_idx_s] <= b_word_s;
            end
            if (a_wr_s) begin
                mem[a_idx_s] <= a_word_s;
            end
        end
    end

    // Port A read source: in write-first mode a same-cycle write to its address is forwarded.
    always_comb begin
        a_rdata_s = '0;
        if ((RDW_MODE == RDW_WRITE_FIRST) && a_wr_s) begin
            a_rdata_s = a_word_s;
        end else if ((RDW_MODE == RDW_WRITE_FIRST) && b_wr_s && same_addr_s) begin
            a_rdata_s = b_word_s;
        end else if (a_inr_s) begin
            a_rdata_s = mem[a_idx_s];
        end else begin
            a_rdata_s = '0;
        end
    end

    // Port B read source: A's write is forwarded first since A's data is what gets stored.
    always_comb begin
        b_rdata_s = '0;
        if ((RDW_MODE == RDW_WRITE_FIRST) && a_wr_s && same_addr_s) begin
            b_rdata_s = a_word_s;
        end else if ((RDW_MODE == RDW_WRITE_FIRST) && b_wr_s) begin
            b_rdata_s = b_word_s;
        end else if (b_inr_s) begin
            b_rdata_s = mem[b_idx_s];
        end else begin
            b_rdata_s = '0;
        end
    end

    // Collision flag: both ports committed a write to the same in-range word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= a_wr_s & b_wr_s & same_addr_s;
        end
    end

    ram_dp_port #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MW(MW)) u_port_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready_i    (ready_s),
        .en_i       (a_en),
        .we_i       (a_we),
        .addr_i     (a_addr),
        .rdata_i    (a_rdata_s),
        .wr_o       (a_wr_s),
        .in_range_o (a_inr_s),
        .dout_o     (a_dout),
        .rvalid_o   (a_rvalid),
        .oob_o      (a_oob),
        .perr_o     (a_perr)
    );

    ram_dp_port #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MW(MW)) u_port_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready_i    (ready_s),
        .en_i       (b_en),
        .we_i       (b_we),
        .addr_i     (b_addr),
        .rdata_i    (b_rdata_s),
        .wr_o       (b_wr_s),
        .in_range_o (b_inr_s),
        .dout_o     (b_dout),
        .rvalid_o   (b_rvalid),
        .oob_o      (b_oob),
        .perr_o     (b_perr)
    );

    assign init_busy = busy_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_ram_dp_sync.sv
// Self-checking bench for ram_dp_sync. Two instances share all inputs:
// u0 = DEPTH 16, read-first, clear value A5A5; u1 = DEPTH 2000, write-first, clear value 0.
module tb_ram_dp_sync;

    logic        clk;
    logic        rst_n;
    logic        a_en, a_we, b_en, b_we;
    logic [10:0] a_addr, b_addr;
    logic [15:0] a_din, b_din;

    logic        u0_busy, u0_a_rv, u0_a_oob, u0_a_perr, u0_b_rv, u0_b_oob, u0_b_perr, u0_coll;
    logic [15:0] u0_a_dout, u0_b_dout;
    logic        u1_busy, u1_a_rv, u1_a_oob, u1_a_perr, u1_b_rv, u1_b_oob, u1_b_perr, u1_coll;
    logic [15:0] u1_a_dout, u1_b_dout;

    int n_tests = 0;
    int n_fail  = 0;

    ram_dp_sync #(.AW(11), .DW(16), .DEPTH(16), .RDW_MODE(0), .CLEAR_VAL(16'hA5A5)) u0 (
        .clk(clk), .rst_n(rst_n), .init_busy(u0_busy),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(u0_a_dout), .a_rvalid(u0_a_rv), .a_oob(u0_a_oob), .a_perr(u0_a_perr),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(u0_b_dout), .b_rvalid(u0_b_rv), .b_oob(u0_b_oob), .b_perr(u0_b_perr),
        .collision(u0_coll)
    );

    ram_dp_sync #(.AW(11), .DW(16), .DEPTH(2000), .RDW_MODE(1), .CLEAR_VAL(16'h0000)) u1 (
        .clk(clk), .rst_n(rst_n), .init_busy(u1_busy),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(u1_a_dout), .a_rvalid(u1_a_rv), .a_oob(u1_a_oob), .a_perr(u1_a_perr),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(u1_b_dout), .b_rvalid(u1_b_rv), .b_oob(u1_b_oob), .b_perr(u1_b_perr),
        .collision(u1_coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        a_en, a_we;
        logic [10:0] a_addr;
        logic [15:0] a_din;
        logic        b_en, b_we;
        logic [10:0] b_addr;
        logic [15:0] b_din;
        logic        a_rv;
        logic [15:0] a_do;
        logic        a_oob;
        logic        b_rv;
        logic [15:0] b_do;
        logic        b_oob;
        logic        coll;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of stimulus; returns #1 after the capturing edge.
    task automatic step(input logic ae, input logic aw, input logic [10:0] aa, input logic [15:0] ad,
                        input logic be, input logic bw, input logic [10:0] ba, input logic [15:0] bd);
        a_en = ae; a_we = aw; a_addr = aa; a_din = ad;
        b_en = be; b_we = bw; b_addr = ba; b_din = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_en = 1'b0; a_we = 1'b0; a_addr = 11'd0; a_din = 16'h0000;
        b_en = 1'b0; b_we = 1'b0; b_addr = 11'd0; b_din = 16'h0000;
    endtask

    initial begin
        int n;
        logic rv_seen;

        // Rows: A inputs, B inputs, then expected u0 outputs after the edge.
        vecs[0]  = '{1'b1,1'b0,11'd0,   16'h0000, 1'b1,1'b0,11'd15, 16'h0000, 1'b1,16'hA5A5,1'b0, 1'b1,16'hA5A5,1'b0, 1'b0};
        vecs[1]  = '{1'b1,1'b0,11'd3,   16'h0000, 1'b1,1'b0,11'd8,  16'h0000, 1'b1,16'hA5A5,1'b0, 1'b1,16'hA5A5,1'b0, 1'b0};
        vecs[2]  = '{1'b1,1'b1,11'd7,   16'h0007, 1'b0,1'b0,11'd0,  16'h0000, 1'b1,16'hA5A5,1'b0, 1'b0,16'hA5A5,1'b0, 1'b0};
        vecs[3]  = '{1'b1,1'b1,11'd5,   16'h1111, 1'b1,1'b1,11'd5,  16'h2222, 1'b1,16'hA5A5,1'b0, 1'b1,16'hA5A5,1'b0, 1'b1};
        vecs[4]  = '{1'b1,1'b0,11'd5,   16'h0000, 1'b1,1'b0,11'd5,  16'h0000, 1'b1,16'h1111,1'b0, 1'b1,16'h1111,1'b0, 1'b0};
        vecs[5]  = '{1'b1,1'b1,11'd7,   16'hBEEF, 1'b1,1'b0,11'd7,  16'h0000, 1'b1,16'h0007,1'b0, 1'b1,16'h0007,1'b0, 1'b0};
        vecs[6]  = '{1'b1,1'b0,11'd7,   16'h0000, 1'b0,1'b0,11'd0,  16'h0000, 1'b1,16'hBEEF,1'b0, 1'b0,16'h0007,1'b0, 1'b0};
        vecs[7]  = '{1'b0,1'b0,11'd0,   16'h0000, 1'b1,1'b1,11'd2,  16'h00FF, 1'b0,16'hBEEF,1'b0, 1'b1,16'hA5A5,1'b0, 1'b0};
        vecs[8]  = '{1'b1,1'b0,11'd2,   16'h0000, 1'b1,1'b1,11'd2,  16'h0102, 1'b1,16'h00FF,1'b0, 1'b1,16'h00FF,1'b0, 1'b0};
        vecs[9]  = '{1'b1,1'b0,11'd2,   16'h0000, 1'b1,1'b0,11'd2,  16'h0000, 1'b1,16'h0102,1'b0, 1'b1,16'h0102,1'b0, 1'b0};
        vecs[10] = '{1'b1,1'b1,11'd2047,16'h5555, 1'b1,1'b0,11'd16, 16'h0000, 1'b1,16'h0000,1'b1, 1'b1,16'h0000,1'b1, 1'b0};
        vecs[11] = '{1'b1,1'b0,11'd2047,16'h0000, 1'b1,1'b0,11'd15, 16'h0000, 1'b1,16'h0000,1'b1, 1'b1,16'hA5A5,1'b0, 1'b0};
        vecs[12] = '{1'b0,1'b0,11'd0,   16'h0000, 1'b0,1'b0,11'd0,  16'h0000, 1'b0,16'h0000,1'b0, 1'b0,16'hA5A5,1'b0, 1'b0};
        vecs[13] = '{1'b1,1'b0,11'd1,   16'h0000, 1'b1,1'b0,11'd1,  16'h0000, 1'b1,16'hA5A5,1'b0, 1'b1,16'hA5A5,1'b0, 1'b0};
        vecs[14] = '{1'b1,1'b1,11'd10,  16'hAAAA, 1'b1,1'b1,11'd11, 16'hBBBB, 1'b1,16'hA5A5,1'b0, 1'b1,16'hA5A5,1'b0, 1'b0};
        vecs[15] = '{1'b1,1'b0,11'd11,  16'h0000, 1'b1,1'b0,11'd10, 16'h0000, 1'b1,16'hBBBB,1'b0, 1'b1,16'hAAAA,1'b0, 1'b0};

        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_busy_u0", {31'd0, u0_busy}, 32'd1);
        chk("rst_busy_u1", {31'd0, u1_busy}, 32'd1);
        chk("rst_outputs_u0", {u0_a_dout, u0_b_dout}, 32'd0);
        chk("rst_flags_u0", {24'd0, u0_a_rv, u0_a_oob, u0_a_perr, u0_b_rv, u0_b_oob, u0_b_perr, u0_coll, 1'b0}, 32'd0);

        // Release reset and request a write to addr 3 throughout the sweep.
        @(negedge clk);
        rst_n = 1'b1;
        a_en = 1'b1; a_we = 1'b1; a_addr = 11'd3; a_din = 16'h1234;
        n = 0;
        rv_seen = 1'b0;
        while (u0_busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (u0_a_rv || u1_a_rv || u0_a_oob || u0_coll) rv_seen = 1'b1;
        end
        idle_inputs();
        chk("clear_cycles", n, 32'd16);
        chk("no_rvalid_during_clear", {31'd0, rv_seen}, 32'd0);
        chk("dout_hold_during_clear", {16'd0, u0_a_dout}, 32'd0);

        // Every word on both ports reads the clear value with 1-cycle latency.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 11'(i), 16'h0000, 1'b1, 1'b0, 11'(15 - i), 16'h0000);
            chk($sformatf("sweep_a_%0d", i), {15'd0, u0_a_rv, u0_a_dout}, {15'd0, 1'b1, 16'hA5A5});
            chk($sformatf("sweep_b_%0d", i), {15'd0, u0_b_rv, u0_b_dout}, {15'd0, 1'b1, 16'hA5A5});
        end

        // Table-driven single-cycle vectors against u0 (read-first).
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].a_en, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_din,
                 vecs[i].b_en, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_din);
            chk($sformatf("vec%0d_a", i), {13'd0, u0_a_rv, u0_a_oob, u0_a_perr, u0_a_dout},
                {13'd0, vecs[i].a_rv, vecs[i].a_oob, 1'b0, vecs[i].a_do});
            chk($sformatf("vec%0d_b", i), {13'd0, u0_b_rv, u0_b_oob, u0_b_perr, u0_b_dout},
                {13'd0, vecs[i].b_rv, vecs[i].b_oob, 1'b0, vecs[i].b_do});
            chk($sformatf("vec%0d_coll", i), {31'd0, u0_coll}, {31'd0, vecs[i].coll});
        end
        idle_inputs();

`ifdef RAM_DP_SYNC_PARITY_EN
        // Corrupt a stored bit and expect the parity flag with the read.
        step(1'b1, 1'b1, 11'd9, 16'h0001, 1'b0, 1'b0, 11'd0, 16'h0000);
        u0.mem[9][0] = ~u0.mem[9][0];
        step(1'b1, 1'b0, 11'd9, 16'h0000, 1'b0, 1'b0, 11'd0, 16'h0000);
        chk("parity_err", {30'd0, u0_a_rv, u0_a_perr}, {30'd0, 1'b1, 1'b1});
        idle_inputs();
`endif

        // Wait for the long sweep of u1.
        n = 0;
        while (u1_busy && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("u1_sweep_done", {31'd0, u1_busy}, 32'd0);

        // u1 write-first sequences.
        step(1'b1, 1'b1, 11'd7, 16'h0007, 1'b1, 1'b0, 11'd7, 16'h0000);
        chk("wf_own_write", {16'd0, u1_a_dout}, {16'd0, 16'h0007});
        step(1'b1, 1'b1, 11'd7, 16'hBEEF, 1'b1, 1'b0, 11'd7, 16'h0000);
        chk("wf_b_reads_a_write", {u1_a_dout, u1_b_dout}, {16'hBEEF, 16'hBEEF});
        chk("wf_rdw_no_coll", {31'd0, u1_coll}, 32'd0);
        step(1'b1, 1'b1, 11'd5, 16'h1111, 1'b1, 1'b1, 11'd5, 16'h2222);
        chk("wf_coll_dout", {u1_a_dout, u1_b_dout}, {16'h1111, 16'h1111});
        chk("wf_coll_flag", {31'd0, u1_coll}, 32'd1);
        step(1'b0, 1'b0, 11'd0, 16'h0000, 1'b0, 1'b0, 11'd0, 16'h0000);
        chk("wf_coll_pulse_end", {29'd0, u1_coll, u1_a_rv, u1_b_rv}, 32'd0);
        step(1'b1, 1'b0, 11'd5, 16'h0000, 1'b0, 1'b0, 11'd0, 16'h0000);
        chk("wf_coll_stored_a", {16'd0, u1_a_dout}, {16'd0, 16'h1111});
        step(1'b1, 1'b1, 11'd2047, 16'h5555, 1'b0, 1'b0, 11'd0, 16'h0000);
        chk("oob_write", {14'd0, u1_a_rv, u1_a_oob, u1_a_dout}, {14'd0, 1'b1, 1'b1, 16'h0000});
        step(1'b1, 1'b0, 11'd2047, 16'h0000, 1'b1, 1'b0, 11'd1023, 16'h0000);
        chk("oob_read", {14'd0, u1_a_rv, u1_a_oob, u1_a_dout}, {14'd0, 1'b1, 1'b1, 16'h0000});
        chk("oob_no_alias_1023", {14'd0, u1_b_rv, u1_b_oob, u1_b_dout}, {14'd0, 1'b1, 1'b0, 16'h0000});
        step(1'b1, 1'b0, 11'd1999, 16'h0000, 1'b1, 1'b0, 11'd2000, 16'h0000);
        chk("last_in_range", {14'd0, u1_a_rv, u1_a_oob, u1_a_dout}, {14'd0, 1'b1, 1'b0, 16'h0000});
        chk("first_oob", {14'd0, u1_b_rv, u1_b_oob, u1_b_dout}, {14'd0, 1'b1, 1'b1, 16'h0000});
        step(1'b1, 1'b0, 11'd12, 16'h0000, 1'b1, 1'b1, 11'd12, 16'h00C3);
        chk("wf_a_reads_b_write", {u1_a_dout, u1_b_dout}, {16'h00C3, 16'h00C3});

        // Reset in the middle of back-to-back writes.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 11'(k), 16'h7000 + 16'(k), 1'b0, 1'b0, 11'd0, 16'h0000);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", {u0_a_dout, u1_a_dout}, 32'd0);
        chk("midrst_flags", {28'd0, u0_a_rv, u1_a_rv, u0_busy, u1_busy}, {28'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (u0_busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midrst_clear_cycles", n, 32'd16);
        step(1'b1, 1'b0, 11'd2, 16'h0000, 1'b1, 1'b0, 11'd7, 16'h0000);
        chk("midrst_recleared", {u0_a_dout, u0_b_dout}, {16'hA5A5, 16'hA5A5});
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_dp_sync.md
Name: ram_dp_sync

Overview:
- Parametrised true dual-port synchronous RAM. It is the next-generation tile/sprite/state store for the game datapath.
- Generalises width and depth, with a 1-cycle read and a valid strobe per port.
- Adds a power-on clear sweep, deterministic same-address collision resolution, selectable read-during-write mode and out-of-range address protection.
- Sits between the game logic (port A) and the VGA renderer (port B).

Parameters:
- AW, 11, address width in bits.
- DW, 16, data width in bits.
- DEPTH, 2048, number of words; must satisfy 1 <= DEPTH <= 2**AW.
- RDW_MODE, 0, read-during-write result: 0 = read-first (old data), 1 = write-first (new data).
- CLEAR_VAL, 0, DW-bit value written to every word by the clear sweep.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_busy  out  1  high while the clear sweep runs; requests are ignored.
- a_en  in  1  port A request.
- a_we  in  1  port A write (valid only with a_en).
- a_addr  in  AW  port A address.
- a_din  in  DW  port A write data.
- a_dout  out  DW  port A read data.
- a_rvalid  out  1  a_dout updated this cycle.
- a_oob  out  1  the request accepted last cycle had addr >= DEPTH.
- a_perr  out  1  parity error on a_dout (see Optional Feature).
- b_en, b_we, b_addr, b_din, b_dout, b_rvalid, b_oob, b_perr: identical to the port A set, for port B.
- collision  out  1  both ports wrote the same in-range address last cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a_dout = b_dout = 0.
  - All rvalid/oob/perr/collision outputs = 0.
  - init_busy = 1, FSM = CLEAR, clr_ptr = 0.
  - Memory contents are not reset directly.
- FSM state CLEAR:
  - Each cycle writes CLEAR_VAL to mem[clr_ptr] and increments clr_ptr.
  - When clr_ptr == DEPTH-1 has been written, the next state is READY and init_busy falls.
  - Sweep length is exactly DEPTH cycles after rst_n deasserts.
- FSM state READY:
  - No exit except reset.
  - Reset mid-sweep or mid-operation restarts CLEAR from 0.
- During CLEAR, port requests:
  - No memory write.
  - rvalid stays 0 and dout holds.
  - oob and collision stay 0.
- Request accept: a request is accepted when en=1 and FSM = READY.
  - Every accepted request, read or write, asserts rvalid at the next edge for exactly 1 cycle. Latency is 1.
  - dout updates only on accepted requests and holds otherwise.
- Write: when we=1 the write is committed at the edge; dout reflects RDW_MODE for the same address.
- Out of range (addr >= DEPTH):
  - The write is dropped.
  - dout = 0, rvalid = 1, oob = 1 for 1 cycle.
- Both ports write the same in-range address in one cycle:
  - Port A data is stored.
  - collision = 1 next cycle.
  - Each port's dout follows RDW_MODE using the stored (A) data when write-first.
- One port writes and the other reads the same address:
  - Reader gets old data (RDW_MODE=0) or the writer's data (RDW_MODE=1).
  - collision = 0.
- Both ports read the same address: both return the same data; no flag.
- Address bits are used in full AW width; there is no silent truncation.

Optional Feature:
- Macro: RAM_DP_SYNC_PARITY_EN.
- Defined:
  - Each word stores DW+1 bits, with even parity computed on write (including the clear sweep).
  - On read, a_perr/b_perr = recomputed parity XOR stored parity, registered with rvalid.
  - Out-of-range reads give perr = 0.
- Undefined: storage is DW bits and a_perr/b_perr are tied 0.

Decomposition:
- Shared package ram_dp_pkg holds:
  - RDW_READ_FIRST / RDW_WRITE_FIRST localparams.
  - FSM state enum {CLEAR, READY}.
  - A parity function.
- One natural sub-module: ram_dp_port, instantiated twice. It holds the per-port accept, oob check, output register, rvalid/oob/perr flags.
- The top holds the memory array, clear FSM and collision logic.

Test Plan:
- Clear sweep:
  - Stimulus: DEPTH=16, CLEAR_VAL=16'hA5A5; release rst_n.
  - Required: init_busy high exactly 16 cycles; then reads of 0..15 on both ports return 16'hA5A5 with rvalid 1 cycle after en.
- Request during clear:
  - Stimulus: during the sweep, a_en=1, a_we=1, addr 3, data 16'h1234.
  - Required: no rvalid; after the sweep, addr 3 reads CLEAR_VAL.
- Collision:
  - Stimulus: A writes 16'h1111 and B writes 16'h2222 to addr 5 in the same cycle.
  - Required: collision pulses 1 cycle; a subsequent read returns 16'h1111.
- Read-during-write, RDW_MODE=0:
  - Stimulus: mem[7]=16'h0007; A writes 16'hBEEF to addr 7 while B reads addr 7.
  - Required: b_dout = 16'h0007.
  - Repeat with RDW_MODE=1: b_dout = 16'hBEEF.
- Out of range:
  - Stimulus: DEPTH=2000; write to addr 2047, then read addr 2047.
  - Required: each request gives oob=1, rvalid=1, dout=0; no memory word changes.
- Parity (RAM_DP_SYNC_PARITY_EN):
  - Stimulus: write 16'h0001; force-flip the stored bit 0; read.
  - Required: a_perr = 1 with rvalid.
- Reset mid-operation:
  - Stimulus: pulse rst_n low during back-to-back writes.
  - Required: outputs zero immediately; sweep restarts from 0.
